turn_controller: RTL and testbench

TURN_CONTROLLER -- requirements
Module: turn_controller

---
 rtl/turn_controller.sv | 127 ++++++++++++
 tb/tb_turn_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_controller.sv
// Turn sequencer for a two-player disk-placing board game: cursor movement,
// move detect/commit handshakes with the board, redraw requests and pass/game-over tracking.
module turn_controller #(
   parameter int unsigned DET_CYCLES  = 9,
   parameter int unsigned WR_CYCLES   = 9,
   parameter int unsigned PLOT_CYCLES = 1280000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_place,
   input  logic       key_pass,
   input  logic [1:0] q,
   input  logic [7:0] dir,
   output logic [2:0] x,
   output logic [2:0] y,
   output logic       side,
   output logic       detecten,
   output logic       writeen,
   output logic       en_plot,
   output logic       busy,
   output logic       illegal,
   output logic       game_over
);

   typedef enum logic [2:0] {
      INIT, IDLE, DETECT, CHECK, WRITE, PLOT, REJECT, OVER
   } state_t;

   localparam int unsigned MAX_DW = (DET_CYCLES > WR_CYCLES) ? DET_CYCLES : WR_CYCLES;
   localparam int unsigned MAXC   = (MAX_DW > PLOT_CYCLES) ? MAX_DW : PLOT_CYCLES;
   localparam int unsigned TW     = ($clog2(MAXC) > 21) ? $clog2(MAXC) : 21;

   localparam logic [TW-1:0] DET_LAST  = TW'(DET_CYCLES - 1);
   localparam logic [TW-1:0] WR_LAST   = TW'(WR_CYCLES - 1);
   localparam logic [TW-1:0] PLOT_LAST = TW'(PLOT_CYCLES - 1);

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [1:0]    pass_cnt, pass_cnt_n;
   logic [2:0]    x_n, y_n;
   logic          side_n;

   // q[0] holds the disk colour, which plays no part in the occupancy decision
   logic unused_q0;
   assign unused_q0 = q[0];

   always_comb begin
      state_n    = state;
      timer_n    = '0;
      pass_cnt_n = pass_cnt;
      x_n        = x;
      y_n        = y;
      side_n     = side;
      case (state)
         INIT: state_n = PLOT;
         IDLE: begin
            if (key_left)       x_n = x - 3'd1;
            else if (key_right) x_n = x + 3'd1;
            else if (key_up)    y_n = y - 3'd1;
            else if (key_down)  y_n = y + 3'd1;
            else if (key_place) state_n = q[1] ? REJECT : DETECT;
            else if (key_pass) begin
               side_n     = ~side;
               pass_cnt_n = pass_cnt + 2'd1;
               if (pass_cnt_n == 2'd2) state_n = PLOT;
            end
         end
         DETECT: begin
            if (timer == DET_LAST) state_n = CHECK;
            else                   timer_n = timer + TW'(1);
         end
         CHECK: state_n = (dir != '0) ? WRITE : REJECT;
         WRITE: begin
            if (timer == WR_LAST) begin
               state_n    = PLOT;
               side_n     = ~side;
               pass_cnt_n = '0;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         PLOT: begin
            if (timer == PLOT_LAST) state_n = (pass_cnt == 2'd2) ? OVER : IDLE;
            else                    timer_n = timer + TW'(1);
         end
         REJECT: state_n = IDLE;
         OVER:   state_n = OVER;
         default: state_n = INIT;
      endcase
   end

   // Outputs are decoded from the next state so each one is a plain flop aligned with state
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= INIT;
         timer     <= '0;
         pass_cnt  <= '0;
         x         <= '0;
         y         <= '0;
         side      <= 1'b0;
         detecten  <= 1'b0;
         writeen   <= 1'b0;
         en_plot   <= 1'b0;
         busy      <= 1'b0;
         illegal   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         pass_cnt  <= pass_cnt_n;
         x         <= x_n;
         y         <= y_n;
         side      <= side_n;
         detecten  <= (state_n == DETECT);
         writeen   <= (state_n == WRITE);
         en_plot   <= (state_n == PLOT);
         busy      <= (state_n != IDLE) && (state_n != OVER);
         illegal   <= (state_n == REJECT);
         game_over <= (state_n == OVER);
      end
   end

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: directed vector table, hand-written multi-cycle sequences and
// random key traffic checked against a transaction-level expected-output queue.
module tb_turn_controller;
   localparam int DET  = 9;
   localparam int WR   = 9;
   localparam int PLOT = 16;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
   logic       key_place = 1'b0, key_pass = 1'b0;
   logic [1:0] q = '0;
   logic [7:0] dir = '0;
   logic [2:0] x, y;
   logic       side, detecten, writeen, en_plot, busy, illegal, game_over;

   turn_controller #(.DET_CYCLES(DET), .WR_CYCLES(WR), .PLOT_CYCLES(PLOT)) dut (
      .clock(clock), .resetn(resetn),
      .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
      .key_place(key_place), .key_pass(key_pass), .q(q), .dir(dir),
      .x(x), .y(y), .side(side), .detecten(detecten), .writeen(writeen), .en_plot(en_plot),
      .busy(busy), .illegal(illegal), .game_over(game_over)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [2:0] x;
      logic [2:0] y;
      logic side, det, wr, plot, busy, ill, over;
   } out_t;

   typedef struct {
      logic [5:0] keys;   // left,right,up,down,place,pass
      logic [1:0] qv;
      logic [2:0] ex, ey;
      logic       es, eb, ei;
   } vec_t;

   int   n_checks = 0, n_fail = 0;
   int   cnt_det = 0, cnt_wr = 0, cnt_plot = 0, cnt_ill = 0;
   out_t exp_q[$];
   logic [2:0] mx, my;
   logic mside, mover, minit;
   int   mpass;

   function automatic out_t rec(input logic s, input logic det, input logic wr, input logic plot,
                                input logic bsy, input logic ill, input logic ovr);
      out_t r;
      r.x = mx; r.y = my; r.side = s; r.det = det; r.wr = wr; r.plot = plot;
      r.busy = bsy; r.ill = ill; r.over = ovr;
      return r;
   endfunction

   function automatic void push_n(input int n, input out_t r);
      for (int i = 0; i < n; i++) exp_q.push_back(r);
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      mx = '0; my = '0; mside = 1'b0; mpass = 0; mover = 1'b0; minit = 1'b1;
   endfunction

   // Expected outputs after one rising edge; whole busy sequences are planned up front
   function automatic out_t model_step(input logic [5:0] k, input logic [1:0] qv, input logic [7:0] dv);
      out_t e;
      if (exp_q.size() != 0) return exp_q.pop_front();
      if (minit) begin
         minit = 1'b0;
         push_n(PLOT - 1, rec(mside, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
         exp_q.push_back(rec(mside, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         return rec(mside, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      if (mover) return rec(mside, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (k[5])      mx = mx - 3'd1;
      else if (k[4]) mx = mx + 3'd1;
      else if (k[3]) my = my - 3'd1;
      else if (k[2]) my = my + 3'd1;
      else if (k[1]) begin
         if (qv[1]) begin
            exp_q.push_back(rec(mside, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            return rec(mside, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         end
         e = rec(mside, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         push_n(DET - 1, e);
         exp_q.push_back(rec(mside, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
         if (dv == 8'h00) begin
            exp_q.push_back(rec(mside, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
         end else begin
            push_n(WR, rec(mside, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
            mside = ~mside;
            mpass = 0;
            push_n(PLOT, rec(mside, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
         end
         exp_q.push_back(rec(mside, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         return e;
      end else if (k[0]) begin
         mside = ~mside;
         mpass++;
         if (mpass == 2) begin
            mover = 1'b1;
            push_n(PLOT - 1, rec(mside, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(rec(mside, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            return rec(mside, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         end
      end
      return rec(mside, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic out_t dut_out();
      out_t r;
      r.x = x; r.y = y; r.side = side; r.det = detecten; r.wr = writeen; r.plot = en_plot;
      r.busy = busy; r.ill = illegal; r.over = game_over;
      return r;
   endfunction

   task automatic chk_out(input string name, input out_t a, input out_t e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h (x,y,side,det,wr,plot,busy,ill,over)",
                  name, $time, a, e);
      end
   endtask

   task automatic chk_int(input string name, input int a, input int e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, a, e);
      end
   endtask

   // Entered and left at a falling edge; keys are one-cycle pulses
   task automatic do_cycle(input logic [5:0] k, input logic [1:0] qv, input logic [7:0] dv);
      out_t e;
      {key_left, key_right, key_up, key_down, key_place, key_pass} = k;
      q = qv;
      dir = dv;
      @(posedge clock);
      e = model_step(k, qv, dv);
      @(negedge clock);
      {key_left, key_right, key_up, key_down, key_place, key_pass} = '0;
      chk_out("cycle", dut_out(), e);
      if (detecten) cnt_det++;
      if (writeen)  cnt_wr++;
      if (en_plot)  cnt_plot++;
      if (illegal)  cnt_ill++;
   endtask

   task automatic settle(input string name);
      for (int i = 0; i < 400 && (exp_q.size() != 0 || minit); i++) do_cycle('0, q, dir);
      if (exp_q.size() != 0 || minit) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: sequence not finished within 400 cycles", name);
      end
   endtask

   task automatic clr_counts();
      cnt_det = 0; cnt_wr = 0; cnt_plot = 0; cnt_ill = 0;
   endtask

   // Reset pulse launched mid-cycle to show the asynchronous clear
   task automatic do_reset_pulse();
      #2 resetn = 1'b0;
      #1 chk_out("async reset", dut_out(), '0);
      model_reset();
      @(negedge clock);
      chk_out("reset hold", dut_out(), '0);
      resetn = 1'b1;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t       vt[13];
      logic [5:0] k;

      vt[0]  = '{6'b100000, 2'b00, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{6'b000100, 2'b00, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{6'b010000, 2'b00, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{6'b001000, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{6'b001000, 2'b00, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{6'b000100, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{6'b100010, 2'b00, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{6'b011000, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{6'b001110, 2'b00, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{6'b000101, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[10] = '{6'b000010, 2'b11, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1};
      vt[11] = '{6'b100000, 2'b11, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[12] = '{6'b000000, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};

      model_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clock);
      chk_out("reset", dut_out(), '0);
      resetn = 1'b1;
      clr_counts();
      settle("init");
      chk_int("init plot cycles", cnt_plot, PLOT);

      for (int i = 0; i < 13; i++) begin
         do_cycle(vt[i].keys, vt[i].qv, 8'h00);
         chk_int($sformatf("vec%0d", i), int'({x, y, side, busy, illegal}),
                 int'({vt[i].ex, vt[i].ey, vt[i].es, vt[i].eb, vt[i].ei}));
      end

      // legal move at (3,2)
      repeat (3) do_cycle(6'b010000, 2'b00, 8'h10);
      repeat (2) do_cycle(6'b000100, 2'b00, 8'h10);
      clr_counts();
      do_cycle(6'b000010, 2'b00, 8'h10);
      settle("legal");
      chk_int("legal det cycles", cnt_det, DET);
      chk_int("legal wr cycles", cnt_wr, WR);
      chk_int("legal plot cycles", cnt_plot, PLOT);
      chk_int("legal side", int'(side), 1);
      chk_int("legal xy", int'({x, y}), int'({3'd3, 3'd2}));

      // empty cell but no flippable direction
      clr_counts();
      do_cycle(6'b000010, 2'b00, 8'h00);
      settle("nodir");
      chk_int("nodir det cycles", cnt_det, DET);
      chk_int("nodir wr cycles", cnt_wr, 0);
      chk_int("nodir illegal cycles", cnt_ill, 1);
      chk_int("nodir side", int'(side), 1);

      // pass, legal move, pass, pass
      do_cycle(6'b000001, 2'b00, 8'h01);
      chk_int("pass1 side", int'(side), 0);
      do_cycle(6'b000010, 2'b00, 8'h01);
      settle("between");
      chk_int("between side", int'(side), 1);
      do_cycle(6'b000001, 2'b00, 8'h01);
      settle("pass2");
      chk_int("counter cleared", int'(game_over), 0);
      clr_counts();
      do_cycle(6'b000001, 2'b00, 8'h01);
      settle("pass3");
      chk_int("over plot cycles", cnt_plot, PLOT);
      chk_int("game over", int'(game_over), 1);
      chk_int("over side", int'(side), 1);
      clr_counts();
      do_cycle(6'b100000, 2'b00, 8'h01);
      do_cycle(6'b000010, 2'b00, 8'h01);
      do_cycle(6'b000001, 2'b00, 8'h01);
      chk_int("over keys ignored", cnt_det + cnt_wr + cnt_plot + cnt_ill, 0);
      chk_int("over xy", int'({x, y, side}), int'({3'd3, 3'd2, 1'b1}));

      // reset out of OVER, then reset during the 4th WRITE cycle
      do_reset_pulse();
      settle("init2");
      do_cycle(6'b000010, 2'b00, 8'h20);
      repeat (DET + 4) do_cycle(6'b000000, 2'b00, 8'h20);
      chk_int("write active", int'(writeen), 1);
      do_reset_pulse();
      clr_counts();
      settle("init3");
      chk_int("init3 plot cycles", cnt_plot, PLOT);

      for (int i = 0; i < 600; i++) begin
         if (exp_q.size() == 0 && !minit) begin
            if (mover && $urandom_range(0, 3) == 0) begin
               do_reset_pulse();
               continue;
            end
            q   = ($urandom_range(0, 3) == 0) ? (2'b10 | 2'($urandom_range(0, 1)))
                                              : 2'($urandom_range(0, 1));
            dir = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         end
         for (int b = 1; b < 6; b++) k[b] = ($urandom_range(0, 7) == 0);
         k[0] = ($urandom_range(0, 15) == 0);
         do_cycle(k, q, dir);
      end
      settle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
